// File: rtl/tracking_pkg.sv
// tracking_pkg: pixel/coordinate types, overlay FSM states and frame constants shared with tracking
package tracking_pkg;
    typedef logic [23:0]        pixel_t;
    typedef logic [11:0]        coord_t;
    typedef logic signed [12:0] edge_t;
    typedef enum logic {S_READ, S_WRITE} state_t;
    localparam int     FRAME_W   = 640;
    localparam int     FRAME_H   = 480;
    localparam pixel_t DEF_COLOR = 24'hFF0000;
endpackage

// File: rtl/box_edges.sv
// box_edges: centre/size to clamped low/high edge on one axis, in 13-bit signed arithmetic
module box_edges import tracking_pkg::*; #(
    parameter int LIM = FRAME_W
) (
    input  logic [11:0]        i_center,
    input  logic [11:0]        i_size,
    output logic signed [12:0] o_lo,
    output logic signed [12:0] o_hi
);
    localparam edge_t MAX = edge_t'(LIM - 1);
    edge_t w_lo, w_hi;
    assign w_lo = $signed({1'b0, i_center}) - $signed({2'b0, i_size[11:1]});
    // high edge comes from the unclamped low edge so a box hanging off the left keeps its width
    assign w_hi = w_lo + $signed({1'b0, i_size}) - 13'sd1;
    assign o_lo = w_lo[12] ? '0 : w_lo;
    assign o_hi = (w_hi > MAX) ? MAX : w_hi;
endmodule

// File: rtl/box_overlay.sv
// box_overlay: draws a COLOR border around the tracked box onto the pixel stream; a new box
// takes effect at the next frame start and expires after HOLD_FRAMES frames without refresh.
module box_overlay import tracking_pkg::*; #(
    parameter int     WIDTH       = FRAME_W,
    parameter int     HEIGHT      = FRAME_H,
    parameter int     THICK       = 2,
    parameter pixel_t COLOR       = DEF_COLOR,
    parameter int     HOLD_FRAMES = 8
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        box_valid,
    input  logic [11:0] box_center_x,
    input  logic [11:0] box_center_y,
    input  logic [11:0] box_width,
    input  logic [11:0] box_height,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        in_rd_en,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [23:0] out_din,
    output logic        frame_done,
    output logic        box_active
);
    localparam coord_t      XMAX = coord_t'(WIDTH - 1);
    localparam coord_t      YMAX = coord_t'(HEIGHT - 1);
    localparam edge_t       TH   = edge_t'(THICK);
    localparam logic [15:0] HOLD = 16'(HOLD_FRAMES);

    state_t      r_state, w_next;
    coord_t      r_x, r_y;
    logic        r_pend;
    logic [15:0] r_cnt, w_cnt_inc;
    edge_t       r_px0, r_px1, r_py0, r_py1, r_ax0, r_ax1, r_ay0, r_ay1;
    edge_t       w_ex0, w_ex1, w_ey0, w_ey1, w_x0, w_x1, w_y0, w_y1, w_xs, w_ys;
    logic        w_load, w_last, w_on, w_inside, w_border;

    box_edges #(.LIM(WIDTH)) u_edges_x (
        .i_center(box_center_x), .i_size(box_width), .o_lo(w_ex0), .o_hi(w_ex1)
    );
    box_edges #(.LIM(HEIGHT)) u_edges_y (
        .i_center(box_center_y), .i_size(box_height), .o_lo(w_ey0), .o_hi(w_ey1)
    );

    always_comb begin
        w_next    = r_state;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (r_state == S_READ) begin
            in_rd_en = reset && !in_empty;
            w_next   = in_empty ? S_READ : S_WRITE;
        end else begin
            out_wr_en = reset && !out_full;
            w_next    = out_full ? S_WRITE : S_READ;
        end
    end

    // the pending box is swapped in while (0,0) is read, so that pixel already uses it
    assign w_load    = in_rd_en && r_x == '0 && r_y == '0 && r_pend;
    assign w_last    = out_wr_en && r_x == XMAX && r_y == YMAX;
    assign w_x0      = w_load ? r_px0 : r_ax0;
    assign w_x1      = w_load ? r_px1 : r_ax1;
    assign w_y0      = w_load ? r_py0 : r_ay0;
    assign w_y1      = w_load ? r_py1 : r_ay1;
    assign w_on      = w_load || box_active;
    assign w_xs      = {1'b0, r_x};
    assign w_ys      = {1'b0, r_y};
    assign w_inside  = w_xs >= w_x0 && w_xs <= w_x1 && w_ys >= w_y0 && w_ys <= w_y1;
    assign w_border  = w_inside && (w_xs - w_x0 < TH || w_x1 - w_xs < TH ||
                                    w_ys - w_y0 < TH || w_y1 - w_ys < TH);
    assign w_cnt_inc = r_cnt + {15'd0, r_cnt != '1};

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_state    <= S_READ;
            r_x        <= '0;
            r_y        <= '0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            {r_px0, r_px1, r_py0, r_py1} <= '0;
            {r_ax0, r_ax1, r_ay0, r_ay1} <= '0;
            out_din    <= '0;
            frame_done <= 1'b0;
            box_active <= 1'b0;
        end else begin
            r_state    <= w_next;
            frame_done <= w_last;
            if (in_rd_en)
                out_din <= (w_on && w_border) ? COLOR : in_dout;
            if (out_wr_en) begin
                r_x <= (r_x == XMAX) ? '0 : r_x + 1'b1;
                if (r_x == XMAX)
                    r_y <= (r_y == YMAX) ? '0 : r_y + 1'b1;
            end
            if (w_last) begin
                r_cnt <= w_cnt_inc;
                if (HOLD_FRAMES != 0 && w_cnt_inc >= HOLD)
                    box_active <= 1'b0;
            end
            if (w_load) begin
                {r_ax0, r_ax1, r_ay0, r_ay1} <= {r_px0, r_px1, r_py0, r_py1};
                r_pend     <= 1'b0;
                r_cnt      <= '0;
                box_active <= 1'b1;
            end
            if (box_valid && box_width != '0 && box_height != '0) begin
                {r_px0, r_px1, r_py0, r_py1} <= {w_ex0, w_ex1, w_ey0, w_ey1};
                r_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_box_overlay.sv
// tb_box_overlay: directed frame-level checks of box_overlay on a reduced 24x16 frame,
// source pixels carry their stream index so loss or duplication shows up as a wrong value.
`timescale 1ns/1ps
module tb_box_overlay;
    localparam int          W    = 24;
    localparam int          H    = 16;
    localparam int          PIX  = W * H;
    localparam int          T    = 2;
    localparam logic [23:0] COL  = 24'h00FF00;

    logic        clock_50 = 1'b0, reset = 1'b0, box_valid = 1'b0, out_full = 1'b0, src_en = 1'b0;
    logic [11:0] box_center_x = '0, box_center_y = '0, box_width = '0, box_height = '0;
    logic        in_empty, in_rd_en, out_wr_en, frame_done, box_active;
    logic [23:0] in_dout, out_din;
    int          src_idx = 0, out_idx = 0, fd_cnt = 0, checks = 0, errors = 0;
    logic [23:0] cap [0:8191];
    int          fd_pos [0:31];
    logic        fd_ba [0:31];

    box_overlay #(.WIDTH(W), .HEIGHT(H), .THICK(T), .COLOR(COL), .HOLD_FRAMES(2)) dut (
        .clock_50(clock_50), .reset(reset), .box_valid(box_valid),
        .box_center_x(box_center_x), .box_center_y(box_center_y),
        .box_width(box_width), .box_height(box_height),
        .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
        .frame_done(frame_done), .box_active(box_active)
    );

    always #10 clock_50 = ~clock_50;
    assign in_empty = !src_en;
    assign in_dout  = {8'h40, src_idx[15:0]};

    always @(posedge clock_50)
        if (!reset) src_idx <= 0;
        else if (in_rd_en && !in_empty) src_idx <= src_idx + 1;

    always @(negedge clock_50) begin
        if (!reset) begin
            out_idx = 0;
            fd_cnt  = 0;
        end else begin
            if (out_wr_en) begin
                if (out_idx < 8192) cap[out_idx] = out_din;
                out_idx++;
            end
            if (frame_done && fd_cnt < 32) begin
                fd_pos[fd_cnt] = out_idx;
                fd_ba[fd_cnt]  = box_active;
                fd_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: out_idx %0d fd_cnt %0d, run did not complete", out_idx, fd_cnt);
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] model(int p, int base, int x0, int x1, int y0, int y1, bit on);
        int x = p % W;
        int y = p / W;
        bit brd = x >= x0 && x <= x1 && y >= y0 && y <= y1 &&
                  (x - x0 < T || x1 - x < T || y - y0 < T || y1 - y < T);
        logic [23:0] din = {8'h40, 16'(base + p)};
        return (on && brd) ? COL : din;
    endfunction

    task automatic set_box(input int cx, input int cy, input int w, input int h);
        box_center_x = 12'(cx);
        box_center_y = 12'(cy);
        box_width    = 12'(w);
        box_height   = 12'(h);
    endtask

    task automatic send_box(input int cx, input int cy, input int w, input int h);
        @(posedge clock_50); #1;
        set_box(cx, cy, w, h);
        box_valid = 1'b1;
        @(posedge clock_50); #1;
        box_valid = 1'b0;
    endtask

    task automatic send_box_at00(input int frame, input int cx, input int cy, input int w, input int h);
        do @(negedge clock_50); while (!(in_rd_en && src_idx == frame * PIX));
        set_box(cx, cy, w, h);
        box_valid = 1'b1;
        @(posedge clock_50); #1;
        box_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        checks += 5;
        if (in_rd_en !== 1'b0)   begin errors++; $display("FAIL reset in_rd_en got %b want 0", in_rd_en); end
        if (out_wr_en !== 1'b0)  begin errors++; $display("FAIL reset out_wr_en got %b want 0", out_wr_en); end
        if (out_din !== 24'h0)   begin errors++; $display("FAIL reset out_din got %h want 0", out_din); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b want 0", frame_done); end
        if (box_active !== 1'b0) begin errors++; $display("FAIL reset box_active got %b want 0", box_active); end
        @(posedge clock_50); #1;
        reset  = 1'b1;
        src_en = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [23:0] e;
        wait (fd_cnt >= 1);
        for (int p = 0; p < PIX; p++) begin
            e = model(p, 0, 0, 0, 0, 0, 1'b0);
            checks++;
            if (cap[p] !== e) begin errors++; $display("FAIL pass f0 x%0d y%0d got %h want %h", p % W, p / W, cap[p], e); end
        end
        checks += 2;
        if (fd_pos[0] !== PIX)   begin errors++; $display("FAIL pass frame_done at pixel %0d want %0d", fd_pos[0], PIX); end
        if (box_active !== 1'b0) begin errors++; $display("FAIL pass box_active got %b want 0", box_active); end
    endtask

    task automatic test_centred();
        logic [23:0] e;
        wait (out_idx >= PIX + 100);
        send_box(12, 8, 11, 11);
        checks++;
        if (box_active !== 1'b0) begin errors++; $display("FAIL centred early box_active got %b want 0", box_active); end
        wait (out_idx >= 2 * PIX + 10);
        checks++;
        if (box_active !== 1'b1) begin errors++; $display("FAIL centred box_active got %b want 1", box_active); end
        wait (out_idx >= 3 * PIX);
        for (int f = 1; f <= 2; f++)
            for (int p = 0; p < PIX; p++) begin
                e = model(p, f * PIX, 7, 17, 3, 13, f == 2);
                checks++;
                if (cap[f * PIX + p] !== e) begin
                    errors++;
                    $display("FAIL centred f%0d x%0d y%0d got %h want %h", f, p % W, p / W, cap[f * PIX + p], e);
                end
            end
    endtask

    task automatic test_expiry();
        logic [23:0] e;
        wait (out_idx >= 3 * PIX + 10);
        checks++;
        if (box_active !== 1'b1) begin errors++; $display("FAIL expiry after 1st frame_done box_active got %b want 1", box_active); end
        wait (fd_cnt >= 4);
        checks += 3;
        if (fd_ba[2] !== 1'b1)     begin errors++; $display("FAIL expiry box_active at fd2 got %b want 1", fd_ba[2]); end
        if (fd_ba[3] !== 1'b0)     begin errors++; $display("FAIL expiry box_active at fd3 got %b want 0", fd_ba[3]); end
        if (fd_pos[3] !== 4 * PIX) begin errors++; $display("FAIL expiry fd3 at pixel %0d want %0d", fd_pos[3], 4 * PIX); end
        for (int p = 0; p < PIX; p++) begin
            e = model(p, 3 * PIX, 7, 17, 3, 13, 1'b1);
            checks++;
            if (cap[3 * PIX + p] !== e) begin
                errors++;
                $display("FAIL expiry f3 x%0d y%0d got %h want %h", p % W, p / W, cap[3 * PIX + p], e);
            end
        end
        wait (out_idx >= 4 * PIX + 20);
        checks++;
        if (box_active !== 1'b0) begin errors++; $display("FAIL expiry frame4 box_active got %b want 0", box_active); end
    endtask

    task automatic test_mid_frame();
        logic [23:0] e;
        int x0 [4:7] = '{0, 3, 0, 0};
        int x1 [4:7] = '{0, 7, 11, 11};
        int y0 [4:7] = '{0, 4, 11, 11};
        int y1 [4:7] = '{0, 6, 15, 15};
        wait (out_idx >= 4 * PIX + 100);
        send_box(5, 5, 5, 3);
        send_box_at00(5, 2, 14, 20, 6);
        wait (out_idx >= 6 * PIX + 50);
        send_box(10, 10, 0, 5);
        wait (out_idx >= 8 * PIX);
        for (int f = 4; f <= 7; f++)
            for (int p = 0; p < PIX; p++) begin
                e = model(p, f * PIX, x0[f], x1[f], y0[f], y1[f], f != 4);
                checks++;
                if (cap[f * PIX + p] !== e) begin
                    errors++;
                    $display("FAIL midframe f%0d x%0d y%0d got %h want %h", f, p % W, p / W, cap[f * PIX + p], e);
                end
            end
    endtask

    task automatic test_back_pressure();
        logic [23:0] e;
        int n0;
        wait (out_idx >= 8 * PIX + 30);
        @(posedge clock_50); #1;
        out_full = 1'b1;
        n0 = out_idx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock_50);
            if (i == 20) begin set_box(20, 2, 4, 4); box_valid = 1'b1; end
            if (i == 21) box_valid = 1'b0;
            if (i >= 2) begin
                checks++;
                if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall cycle %0d rd %b wr %b want 0 0", i, in_rd_en, out_wr_en);
                end
            end
        end
        @(posedge clock_50); #1;
        out_full = 1'b0;
        checks++;
        if (out_idx !== n0) begin errors++; $display("FAIL stall pushes got %0d want %0d", out_idx, n0); end
        wait (out_idx >= 10 * PIX);
        for (int f = 8; f <= 9; f++)
            for (int p = 0; p < PIX; p++) begin
                e = model(p, f * PIX, 18, 21, 0, 3, f == 9);
                checks++;
                if (cap[f * PIX + p] !== e) begin
                    errors++;
                    $display("FAIL stall f%0d x%0d y%0d got %h want %h", f, p % W, p / W, cap[f * PIX + p], e);
                end
            end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] e;
        wait (out_idx >= 10 * PIX + 40);
        send_box(12, 8, 11, 11);
        wait (out_idx >= 10 * PIX + 80);
        @(posedge clock_50); #1;
        reset  = 1'b0;
        src_en = 1'b0;
        @(posedge clock_50);
        @(negedge clock_50);
        checks += 5;
        if (in_rd_en !== 1'b0)   begin errors++; $display("FAIL midreset in_rd_en got %b want 0", in_rd_en); end
        if (out_wr_en !== 1'b0)  begin errors++; $display("FAIL midreset out_wr_en got %b want 0", out_wr_en); end
        if (out_din !== 24'h0)   begin errors++; $display("FAIL midreset out_din got %h want 0", out_din); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset frame_done got %b want 0", frame_done); end
        if (box_active !== 1'b0) begin errors++; $display("FAIL midreset box_active got %b want 0", box_active); end
        @(posedge clock_50); #1;
        reset  = 1'b1;
        src_en = 1'b1;
        wait (fd_cnt >= 2);
        for (int f = 0; f <= 1; f++)
            for (int p = 0; p < PIX; p++) begin
                e = model(p, f * PIX, 0, 0, 0, 0, 1'b0);
                checks++;
                if (cap[f * PIX + p] !== e) begin
                    errors++;
                    $display("FAIL midreset f%0d x%0d y%0d got %h want %h", f, p % W, p / W, cap[f * PIX + p], e);
                end
            end
        checks += 2;
        if (fd_pos[0] !== PIX)   begin errors++; $display("FAIL midreset fd0 at pixel %0d want %0d", fd_pos[0], PIX); end
        if (box_active !== 1'b0) begin errors++; $display("FAIL midreset box_active got %b want 0", box_active); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_centred();
        test_expiry();
        test_mid_frame();
        test_back_pressure();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/box_overlay.md
# box_overlay

Draws a rectangular border onto the outgoing 640x480 RGB pixel stream, using the bounding box reported by the tracking block. Sits downstream of tracking, between an input pixel FIFO and the display-side output FIFO, in the 50 MHz domain. A received box is applied only at a frame boundary, so no frame tears. A box expires after a configurable number of frames without a refresh.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- THICK, 2, border thickness in pixels (1..15)
- COLOR, 24'hFF0000, border colour, {R,G,B}
- HOLD_FRAMES, 8, frames a box stays drawn without refresh; 0 = never expires
- clock_50  in  1  sole clock
- reset  in  1  synchronous, active-low
- box_valid  in  1  one-cycle pulse, box fields valid
- box_center_x  in  12  box centre column
- box_center_y  in  12  box centre row
- box_width  in  12  box width in pixels
- box_height  in  12  box height in pixels
- in_empty  in  1  input FIFO empty (first-word-fall-through)
- in_dout  in  24  input pixel {R,G,B}; valid whenever !in_empty
- in_rd_en  out  1  pop input FIFO
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push output FIFO
- out_din  out  24  output pixel
- frame_done  out  1  one-cycle pulse when the last pixel (WIDTH-1, HEIGHT-1) is pushed
- box_active  out  1  border currently being drawn

## Operation
- **FSM** S_READ / S_WRITE.
  - S_READ: if !in_empty, assert in_rd_en, register in_dout and the border flag for (x,y), go to S_WRITE.
  - S_WRITE: if !out_full, assert out_wr_en, advance coordinates, go to S_READ. Otherwise hold.
- **Coordinates**: x wraps at WIDTH-1 and then increments y; y wraps at HEIGHT-1 to 0.
- **Edge computation** at box_valid, in 13-bit signed arithmetic:
  - x0 = cx - (w>>1), clamped to ≥0.
  - x1 = (cx - (w>>1)) + w - 1, computed from the unclamped x0 and clamped to ≤WIDTH-1.
  - y0 and y1 are computed the same way against HEIGHT.
  - The results are stored in pending registers and the pending flag is set.
  - A box with w==0 or h==0 is ignored.
- **Frame-boundary load**: when a pixel is read at (0,0):
  - If pending is set: active ← pending, clear pending, clear frame counter.
  - Otherwise active is kept.
  - A box_valid in that same cycle updates pending only; it is applied next frame.
- **Border test**: the pixel is in the box if x0≤x≤x1 and y0≤y≤y1. It is border if also any of x-x0, x1-x, y-y0, y1-y is < THICK.
  - Border pixels are replaced by COLOR when box_active; all other pixels pass through unchanged.
- **Expiry**: the frame counter increments (saturating) on frame_done. When HOLD_FRAMES≠0 and counter ≥ HOLD_FRAMES, box_active drops to 0 and stays 0 until the next load.
- **Reset** (mid-frame included):
  - State goes to S_READ; x, y, pending flag, active box and counter are cleared.
  - The partial frame is abandoned; upstream is reset together.

## Timing
- Reset values: in_rd_en 0, out_wr_en 0, out_din 0, frame_done 0, box_active 0.
- in_rd_en and out_wr_en are combinational from state, in_empty and out_full. out_din, frame_done and box_active are registered.
- Latency: a pixel popped in cycle N is pushed in cycle N+1 at the earliest, and later while out_full holds.
- Peak throughput is 1 pixel per 2 cycles, which matches the 25 MHz pixel rate.
- in_rd_en is never asserted in S_WRITE, so at most one pixel is in flight.
- box_valid is accepted in any state and on any cycle, including during stalls.
- box_active rises in the cycle after the (0,0) load.

## Structure
- Shared package tracking_pkg holds:
  - pixel_t (logic[23:0]) and coord_t (logic[11:0]);
  - the state enum;
  - the default COLOR and frame-size constants, also used by tracking.
- One sub-module, box_edges: combinational centre/size → clamped x0, x1, y0, y1 for one axis. Instantiate it twice (x and y).

## Test plan
- **Centred box**: box (cx=320, cy=240, w=11, h=11), THICK=1, gray frame.
  - Next frame: border at x∈{315,325} for y 235..245, and at y∈{235,245} for x 315..325, set to COLOR.
  - All other pixels are unchanged.
- **Clamping**: box (cx=2, cy=2, w=20, h=20).
  - Next frame: x0=y0=0 and x1=y1=11.
  - No wrap artefacts appear at x=639.
- **Mid-frame update**: box_valid pulsed mid-frame, and also in the same cycle as the (0,0) read.
  - The current frame is unchanged.
  - The same-cycle box appears one frame later than a box that arrives earlier.
- **Back-pressure**: hold out_full high for 50 cycles mid-line.
  - in_rd_en stays low; no pixel is lost or duplicated.
  - The output sequence matches the reference model.
- **Expiry**: HOLD_FRAMES=2, one box, then none.
  - The border is drawn in frames 1–2 and is absent from frame 3.
  - box_active falls after the second frame_done.
- **Reset**: assert reset mid-frame.
  - All outputs go to 0 and coordinates restart at (0,0).
  - No border is drawn until a new box loads.
